stream_traffic_gen: RTL and testbench

Configurable AXI-Stream traffic source that drives the external data path observed by the throughput monitor. The HLS frontend configures it over a 64-bit cfg stream. It emits a run of beats with a deterministic payload, packet framing and inter-beat gaps, then returns a 64-bit completion report on a status stream. Used as the stimulus end of throughput measurements.

---
 rtl/stream_traffic_gen.sv | 192 +++++++++++++++++++
 tb/tb_stream_traffic_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stream_traffic_gen.sv
// stream_traffic_gen: configurable AXI-Stream traffic source.
// A 64-bit cfg word sets the run length, packet length and inter-beat gap.
// The block emits the run and then returns {stall_cnt, beats_sent} on the
// done stream.
module stream_traffic_gen #(
    parameter int DATA_WIDTH = 512
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,

    output logic [DATA_WIDTH-1:0]   m_axis_out_tdata,
    output logic                    m_axis_out_tvalid,
    input  logic                    m_axis_out_tready,
    output logic [DATA_WIDTH/8-1:0] m_axis_out_tkeep,
    output logic                    m_axis_out_tlast,

    input  logic [63:0]             cfg_TDATA,
    input  logic                    cfg_TVALID,
    output logic                    cfg_TREADY,

    output logic [63:0]             done_TDATA,
    output logic                    done_TVALID,
    input  logic                    done_TREADY
);

    localparam int WORDS = DATA_WIDTH / 32;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        REPORT
    } state_t;

    state_t                  state;

    // Latched run configuration
    logic [31:0]             num_beats;
    logic [15:0]             pkt_len;      // already forced to >= 1
    logic [15:0]             gap_len;

    // Run counters
    logic [31:0]             beat_idx;
    logic [31:0]             pkt_cnt;
    logic [31:0]             stall_cnt;
    logic [15:0]             gap_cnt;

    // Registered outputs
    logic [DATA_WIDTH-1:0]   tdata_r;
    logic                    tvalid_r;
    logic                    tlast_r;
    logic                    cfg_tready_r;
    logic [63:0]             done_data_r;
    logic                    done_valid_r;

    // Decoded fields of the incoming cfg word
    logic [31:0]             cfg_num_beats;
    logic [15:0]             cfg_pkt_len;
    logic [15:0]             cfg_gap;

    // Position of the beat that follows the current one
    logic [31:0]             next_idx;
    logic [31:0]             next_pkt;
    logic                    last_beat;

    // A beat closes its packet at the packet boundary or at the end of the run.
    function automatic logic beat_is_last(input logic [31:0] idx,
                                          input logic [31:0] pkt,
                                          input logic [31:0] nb,
                                          input logic [15:0] pl);
        return (pkt == ({16'd0, pl} - 32'd1)) || (idx == (nb - 32'd1));
    endfunction

    // Payload is the beat index repeated across every 32-bit lane.
    function automatic logic [DATA_WIDTH-1:0] payload(input logic [31:0] idx);
        return {WORDS{idx}};
    endfunction

    // Decode cfg fields and compute the advance of the beat/packet counters.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch can be inferred.
        cfg_num_beats = cfg_TDATA[31:0];
        cfg_pkt_len   = (cfg_TDATA[47:32] == 16'd0) ? 16'd1 : cfg_TDATA[47:32];
        cfg_gap       = cfg_TDATA[63:48];
        next_idx      = beat_idx + 32'd1;
        next_pkt      = tlast_r ? 32'd0 : (pkt_cnt + 32'd1);
        last_beat     = (beat_idx == (num_beats - 32'd1));
    end

    // Main FSM: configuration, beat generation, gaps and the completion report.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state        <= IDLE;
            num_beats    <= '0;
            pkt_len      <= '0;
            gap_len      <= '0;
            beat_idx     <= '0;
            pkt_cnt      <= '0;
            stall_cnt    <= '0;
            gap_cnt      <= '0;
            tdata_r      <= '0;
            tvalid_r     <= 1'b0;
            tlast_r      <= 1'b0;
            cfg_tready_r <= 1'b1;
            done_data_r  <= '0;
            done_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_TVALID && cfg_tready_r) begin
                        num_beats    <= cfg_num_beats;
                        pkt_len      <= cfg_pkt_len;
                        gap_len      <= cfg_gap;
                        beat_idx     <= '0;
                        pkt_cnt      <= '0;
                        stall_cnt    <= '0;
                        cfg_tready_r <= 1'b0;
                        if (cfg_num_beats == 32'd0) begin
                            state        <= REPORT;
                            done_valid_r <= 1'b1;
                            done_data_r  <= 64'd0;
                        end else begin
                            state    <= SEND;
                            tvalid_r <= 1'b1;
                            tdata_r  <= payload(32'd0);
                            tlast_r  <= beat_is_last(32'd0, 32'd0, cfg_num_beats, cfg_pkt_len);
                        end
                    end
                end

                SEND: begin
                    if (m_axis_out_tready) begin
                        beat_idx <= next_idx;
                        pkt_cnt  <= next_pkt;
                        if (last_beat) begin
                            state        <= REPORT;
                            tvalid_r     <= 1'b0;
                            tlast_r      <= 1'b0;
                            done_valid_r <= 1'b1;
                            done_data_r  <= {stall_cnt, next_idx};
                        end else if (gap_len == 16'd0) begin
                            tdata_r <= payload(next_idx);
                            tlast_r <= beat_is_last(next_idx, next_pkt, num_beats, pkt_len);
                        end else begin
                            state    <= GAP;
                            tvalid_r <= 1'b0;
                            tlast_r  <= 1'b0;
                            gap_cnt  <= gap_len;
                        end
                    end else if (stall_cnt != 32'hFFFF_FFFF) begin
                        // Beat is held stable; count the back-pressure cycle.
                        stall_cnt <= stall_cnt + 32'd1;
                    end
                end

                GAP: begin
                    // gap_cnt counts the idle cycles still to show, including this one.
                    if (gap_cnt == 16'd1) begin
                        state    <= SEND;
                        tvalid_r <= 1'b1;
                        tdata_r  <= payload(beat_idx);
                        tlast_r  <= beat_is_last(beat_idx, pkt_cnt, num_beats, pkt_len);
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end

                REPORT: begin
                    if (done_TREADY) begin
                        state        <= IDLE;
                        done_valid_r <= 1'b0;
                        cfg_tready_r <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign m_axis_out_tdata  = tdata_r;
    assign m_axis_out_tvalid = tvalid_r;
    assign m_axis_out_tlast  = tlast_r;
    assign m_axis_out_tkeep  = '1;
    assign cfg_TREADY        = cfg_tready_r;
    assign done_TDATA        = done_data_r;
    assign done_TVALID       = done_valid_r;

endmodule

// File: tb/tb_stream_traffic_gen.sv
// Self-checking bench for stream_traffic_gen: directed runs from the test plan
// plus randomised runs, checked against a beat-level model of the stream.
module tb_stream_traffic_gen;

    localparam int DW = 512;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n = 1'b0;
    logic [DW-1:0]   m_axis_out_tdata;
    logic            m_axis_out_tvalid;
    logic            m_axis_out_tready = 1'b0;
    logic [DW/8-1:0] m_axis_out_tkeep;
    logic            m_axis_out_tlast;
    logic [63:0]     cfg_TDATA = '0;
    logic            cfg_TVALID = 1'b0;
    logic            cfg_TREADY;
    logic [63:0]     done_TDATA;
    logic            done_TVALID;
    logic            done_TREADY = 1'b0;

    int tests  = 0;
    int failed = 0;

    stream_traffic_gen #(.DATA_WIDTH(DW)) dut (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .m_axis_out_tdata  (m_axis_out_tdata),
        .m_axis_out_tvalid (m_axis_out_tvalid),
        .m_axis_out_tready (m_axis_out_tready),
        .m_axis_out_tkeep  (m_axis_out_tkeep),
        .m_axis_out_tlast  (m_axis_out_tlast),
        .cfg_TDATA         (cfg_TDATA),
        .cfg_TVALID        (cfg_TVALID),
        .cfg_TREADY        (cfg_TREADY),
        .done_TDATA        (done_TDATA),
        .done_TVALID       (done_TVALID),
        .done_TREADY       (done_TREADY)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected payload for beat i: the 32-bit index in every lane.
    function automatic logic [DW-1:0] exp_payload(input int unsigned i);
        logic [31:0]   w;
        logic [DW-1:0] d;
        w = i;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = w;
        return d;
    endfunction

    // One complete run: configure, observe every cycle of the stream, then
    // take the report. Beat i of a run of n with packet length pl carries
    // payload i and is tlast when i%pl == pl-1 or i == n-1; after each
    // accepted non-final beat the stream is idle for exactly gap cycles.
    task automatic run(input int unsigned n, input int unsigned pl_raw,
                       input int unsigned gap, input int stall_pct,
                       input int hold0, input int done_hold, input string name);
        int unsigned pl;
        int unsigned idx;
        int unsigned gap_left;
        int unsigned stalls;
        int          held;
        int          cyc;
        logic [63:0] exp_report;

        pl       = (pl_raw == 0) ? 1 : pl_raw;
        idx      = 0;
        gap_left = 0;
        stalls   = 0;
        held     = 0;
        cyc      = 0;

        @(negedge ap_clk);
        chk({name, ".cfg_ready_idle"}, 64'(cfg_TREADY), 64'd1);
        cfg_TDATA  = {gap[15:0], pl_raw[15:0], n[31:0]};
        cfg_TVALID = 1'b1;
        m_axis_out_tready = 1'b1;
        @(negedge ap_clk);
        cfg_TVALID = 1'b0;

        while (idx < n && cyc < 2000) begin
            chk({name, ".tvalid"}, 64'(m_axis_out_tvalid), 64'(gap_left == 0));
            chk({name, ".cfg_ready_busy"}, 64'(cfg_TREADY), 64'd0);
            if (gap_left == 0) begin
                chk_data({name, ".tdata"}, m_axis_out_tdata, exp_payload(idx));
                chk({name, ".tlast"}, 64'(m_axis_out_tlast),
                    64'(((idx % pl) == pl - 1) || (idx == n - 1)));
                chk({name, ".tkeep"}, m_axis_out_tkeep, '1);
                if (idx == 0 && held < hold0) begin
                    m_axis_out_tready = 1'b0;
                    held++;
                end else begin
                    m_axis_out_tready = ($urandom_range(99) >= stall_pct);
                end
                if (m_axis_out_tready) begin
                    idx++;
                    gap_left = (idx < n) ? gap : 0;
                end else begin
                    stalls++;
                end
            end else begin
                m_axis_out_tready = $urandom_range(1);
                gap_left--;
            end
            cyc++;
            @(negedge ap_clk);
        end
        if (cyc >= 2000) chk({name, ".stream_timeout"}, 64'd0, 64'd1);

        exp_report = {stalls[31:0], n[31:0]};
        m_axis_out_tready = 1'b1;
        for (int h = 0; h < done_hold; h++) begin
            chk({name, ".done_valid_hold"}, 64'(done_TVALID), 64'd1);
            chk({name, ".done_data_hold"}, done_TDATA, exp_report);
            chk({name, ".cfg_ready_report"}, 64'(cfg_TREADY), 64'd0);
            @(negedge ap_clk);
        end
        chk({name, ".tvalid_report"}, 64'(m_axis_out_tvalid), 64'd0);
        chk({name, ".done_valid"}, 64'(done_TVALID), 64'd1);
        chk({name, ".done_data"}, done_TDATA, exp_report);
        done_TREADY = 1'b1;
        @(negedge ap_clk);
        done_TREADY = 1'b0;
        chk({name, ".done_valid_clr"}, 64'(done_TVALID), 64'd0);
        chk({name, ".cfg_ready_back"}, 64'(cfg_TREADY), 64'd1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.tvalid", 64'(m_axis_out_tvalid), 64'd0);
        chk("rst.tlast", 64'(m_axis_out_tlast), 64'd0);
        chk_data("rst.tdata", m_axis_out_tdata, '0);
        chk("rst.tkeep", m_axis_out_tkeep, '1);
        chk("rst.cfg_ready", 64'(cfg_TREADY), 64'd1);
        chk("rst.done_valid", 64'(done_TVALID), 64'd0);
        chk("rst.done_data", done_TDATA, 64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Directed runs from the test plan
        run(4, 2, 0, 0, 0, 0, "b2b");
        run(3, 3, 3, 0, 0, 0, "gap3");
        run(2, 1, 0, 0, 5, 4, "stall5");
        run(0, 1, 0, 0, 0, 2, "zero");
        run(5, 0, 0, 0, 0, 0, "pkt0");
        run(3, 8, 0, 0, 0, 0, "pkt8");

        // Reset in the middle of a run
        @(negedge ap_clk);
        cfg_TDATA  = {16'd0, 16'd4, 32'd10};
        cfg_TVALID = 1'b1;
        m_axis_out_tready = 1'b1;
        @(negedge ap_clk);
        cfg_TVALID = 1'b0;
        @(negedge ap_clk);
        chk("midrst.tvalid_before", 64'(m_axis_out_tvalid), 64'd1);
        ap_rst_n = 1'b0;
        #1;
        chk("midrst.tvalid", 64'(m_axis_out_tvalid), 64'd0);
        chk("midrst.cfg_ready", 64'(cfg_TREADY), 64'd1);
        chk("midrst.done_valid", 64'(done_TVALID), 64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        run(6, 4, 1, 0, 0, 0, "after_rst");

        // Randomised runs with random back-pressure and report delay
        for (int r = 0; r < 8; r++) begin
            run($urandom_range(1, 12), $urandom_range(0, 5), $urandom_range(0, 3),
                30, 0, $urandom_range(0, 3), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
